// File: rtl/md_unit_ctrl.sv
// -----------------------------------------------------------------------------
// md_unit_ctrl
//
// This module sequences multiply and divide operations in the EX stage of the
// pipelined MIPS core. It accepts mult, multu, div, divu, mthi and mtlo
// commands. It owns the architectural HI/LO registers. A busy counter models the
// fixed latency of each operation.
//
// mult and div results are computed on the accepting edge into pending
// registers. They are copied into HI/LO only when the counter expires, so HI/LO
// keep their old values for the whole time the operation is in flight.
//
// Ports
//   clk        core clock, rising edge
//   reset      asynchronous, active-high reset
//   Start      command strobe: the EX-stage instruction is an MD op
//   MDOp       0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 rsvd
//   A          rs operand (dividend / multiplicand / mthi-mtlo source)
//   B          rt operand (divisor / multiplier)
//   Busy       registered: a mult/div operation is in flight
//   Stall      combinational Busy | (Start & MDOp in 1..4), to hazard unit
//   HI, LO     registered HI/LO architectural registers
//   dbg_state  current FSM state (0 IDLE, 1 RUN) for observation
//
// Handshake: Start is a single-cycle command strobe with no ready signal. A
// command is consumed at the edge where Start=1, provided the unit is IDLE.
// While Busy=1 every command is ignored; the hazard unit keeps MD instructions
// in ID, using Stall to do so.
// -----------------------------------------------------------------------------
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        dbg_state
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q, state_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic             busy_q, busy_next;
  logic [31:0]      hi_q, hi_next;
  logic [31:0]      lo_q, lo_next;
  logic [31:0]      pend_hi_q, pend_hi_next;
  logic [31:0]      pend_lo_q, pend_lo_next;
  // Cleared for divide-by-zero so that completion leaves HI/LO untouched.
  logic             pend_ok_q, pend_ok_next;

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  logic is_mult, is_multu, is_div, is_divu, is_mul_op, is_div_op;
  logic is_mthi, is_mtlo;

  assign is_mult   = Start && (MDOp == OP_MULT);
  assign is_multu  = Start && (MDOp == OP_MULTU);
  assign is_div    = Start && (MDOp == OP_DIV);
  assign is_divu   = Start && (MDOp == OP_DIVU);
  assign is_mthi   = Start && (MDOp == OP_MTHI);
  assign is_mtlo   = Start && (MDOp == OP_MTLO);
  assign is_mul_op = is_mult || is_multu;
  assign is_div_op = is_div  || is_divu;

  // ---------------------------------------------------------------------------
  // Multiply datapath
  // ---------------------------------------------------------------------------
  logic [63:0] mul_s;
  logic [63:0] mul_u;
  logic [63:0] mul_res;

  assign mul_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign mul_u   = {32'd0, A} * {32'd0, B};
  assign mul_res = is_mult ? mul_s : mul_u;

  // ---------------------------------------------------------------------------
  // Divide datapath
  //
  // Signed division works on magnitudes and then applies the signs. The
  // quotient is negative when the operand signs differ, so it truncates toward
  // zero. The remainder takes the sign of the dividend. Because of this,
  // 0x80000000 / -1 needs no special case: the magnitude 0x80000000 negates
  // back to itself and the remainder is 0. The divisor is forced to 1 when B is
  // 0, so the divider never sees a zero divisor. That result is discarded
  // anyway.
  // ---------------------------------------------------------------------------
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] q_mag, r_mag;
  logic [31:0] quot, rem;
  logic        div_by_zero;

  assign a_neg       = is_div && A[31];
  assign b_neg       = is_div && B[31];
  assign a_mag       = a_neg ? (~A + 32'd1) : A;
  assign b_mag       = b_neg ? (~B + 32'd1) : B;
  assign div_by_zero = (B == 32'd0);
  assign b_safe      = div_by_zero ? 32'd1 : b_mag;
  assign q_mag       = a_mag / b_safe;
  assign r_mag       = a_mag % b_safe;
  assign quot        = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem         = a_neg ? (~r_mag + 32'd1) : r_mag;

  // ---------------------------------------------------------------------------
  // FSM: next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_q;
    cnt_next     = cnt_q;
    busy_next    = busy_q;
    hi_next      = hi_q;
    lo_next      = lo_q;
    pend_hi_next = pend_hi_q;
    pend_lo_next = pend_lo_q;
    pend_ok_next = pend_ok_q;

    unique case (state_q)
      IDLE: begin
        if (is_mul_op) begin
          pend_hi_next = mul_res[63:32];
          pend_lo_next = mul_res[31:0];
          pend_ok_next = 1'b1;
          cnt_next     = MULT_LOAD;
          busy_next    = 1'b1;
          state_next   = RUN;
        end else if (is_div_op) begin
          pend_hi_next = rem;
          pend_lo_next = quot;
          pend_ok_next = !div_by_zero;
          cnt_next     = DIV_LOAD;
          busy_next    = 1'b1;
          state_next   = RUN;
        end else if (is_mthi) begin
          hi_next = A;
        end else if (is_mtlo) begin
          lo_next = A;
        end
      end

      RUN: begin
        // Start is ignored here. The counter reaching 0 retires the operation.
        if (cnt_q <= CNT_ONE) begin
          cnt_next   = CNT_ZERO;
          busy_next  = 1'b0;
          state_next = IDLE;
          if (pend_ok_q) begin
            hi_next = pend_hi_q;
            lo_next = pend_lo_q;
          end
        end else begin
          cnt_next = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_ok_q <= 1'b0;
    end else begin
      state_q   <= state_next;
      cnt_q     <= cnt_next;
      busy_q    <= busy_next;
      hi_q      <= hi_next;
      lo_q      <= lo_next;
      pend_hi_q <= pend_hi_next;
      pend_lo_q <= pend_lo_next;
      pend_ok_q <= pend_ok_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Busy      = busy_q;
  assign Stall     = busy_q || is_mul_op || is_div_op;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign dbg_state = (state_q == RUN);

endmodule

// File: tb/tb_md_unit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_unit_ctrl
//
// Directed testbench for md_unit_ctrl with MULT_CYCLES=5 and DIV_CYCLES=10.
// Inputs are driven and outputs are sampled on the falling clock edge. Each
// scenario task leaves the bench parked on a falling edge.
// -----------------------------------------------------------------------------
module tb_md_unit_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam int BUSY_LIMIT = 50;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Stall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        dbg_state;

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  md_unit_ctrl #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .MDOp     (MDOp),
    .A        (A),
    .B        (B),
    .Busy     (Busy),
    .Stall    (Stall),
    .HI       (HI),
    .LO       (LO),
    .dbg_state(dbg_state)
  );

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called while parked on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic drive_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    @(negedge clk);
    Start = 1'b0;
    MDOp  = 3'd0;
    A     = 32'd0;
    B     = 32'd0;
  endtask

  // Count falling edges that see Busy=1. The count stops at the first edge
  // that sees Busy=0, or at BUSY_LIMIT.
  task automatic wait_busy(output int cycles);
    cycles = 0;
    while (Busy === 1'b1 && cycles < BUSY_LIMIT) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    reset = 1'b1;
    Start = 1'b0;
    MDOp  = 3'd0;
    A     = 32'd0;
    B     = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 00000000", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 00000000", LO); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", Stall); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state got %b exp 0", dbg_state); end
  endtask

  task automatic test_mult;
    int cyc;
    // Signed: -2 * 3 = -6.
    drive_cmd(3'd1, 32'hFFFF_FFFE, 32'd3);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL mult_busy_rise got %b exp 1", Busy); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL mult_hi_hold got %h exp 00000000", HI); end
    wait_busy(cyc);
    checks++; if (cyc != MULT_N) begin errors++; $display("FAIL mult_busy_cycles got %0d exp %0d", cyc, MULT_N); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", HI); end
    checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h exp fffffffa", LO); end
    // Unsigned: (2^32-2)*3 = 0x2_FFFFFFFA.
    drive_cmd(3'd2, 32'hFFFF_FFFE, 32'd3);
    wait_busy(cyc);
    checks++; if (cyc != MULT_N) begin errors++; $display("FAIL multu_busy_cycles got %0d exp %0d", cyc, MULT_N); end
    checks++; if (HI !== 32'h0000_0002) begin errors++; $display("FAIL multu_hi got %h exp 00000002", HI); end
    checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo got %h exp fffffffa", LO); end
  endtask

  task automatic test_div;
    int cyc;
    // Signed: -7 / 2 = -3 rem -1.
    drive_cmd(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_busy(cyc);
    checks++; if (cyc != DIV_N) begin errors++; $display("FAIL div_busy_cycles got %0d exp %0d", cyc, DIV_N); end
    checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", LO); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", HI); end
    // Unsigned: 7 / 2 = 3 rem 1.
    drive_cmd(3'd4, 32'd7, 32'd2);
    wait_busy(cyc);
    checks++; if (cyc != DIV_N) begin errors++; $display("FAIL divu_busy_cycles got %0d exp %0d", cyc, DIV_N); end
    checks++; if (LO !== 32'd3) begin errors++; $display("FAIL divu_lo got %h exp 00000003", LO); end
    checks++; if (HI !== 32'd1) begin errors++; $display("FAIL divu_hi got %h exp 00000001", HI); end
    // Signed corner: 0x80000000 / -1.
    drive_cmd(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy(cyc);
    checks++; if (LO !== 32'h8000_0000) begin errors++; $display("FAIL div_corner_lo got %h exp 80000000", LO); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL div_corner_hi got %h exp 00000000", HI); end
    // Unsigned with the top bit set: 0x80000000 / 3 = 0x2AAAAAAA rem 2.
    drive_cmd(3'd4, 32'h8000_0000, 32'd3);
    wait_busy(cyc);
    checks++; if (LO !== 32'h2AAA_AAAA) begin errors++; $display("FAIL divu_big_lo got %h exp 2aaaaaaa", LO); end
    checks++; if (HI !== 32'd2) begin errors++; $display("FAIL divu_big_hi got %h exp 00000002", HI); end
  endtask

  task automatic test_mthi_mtlo_div0;
    int cyc;
    // mthi: Stall stays low, Busy never rises, LO keeps the previous value (2aaaaaaa).
    Start = 1'b1; MDOp = 3'd5; A = 32'h11; B = 32'd0;
    #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL mthi_stall got %b exp 0", Stall); end
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd0; A = 32'd0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", Busy); end
    checks++; if (HI !== 32'h11) begin errors++; $display("FAIL mthi_hi got %h exp 00000011", HI); end
    checks++; if (LO !== 32'h2AAA_AAAA) begin errors++; $display("FAIL mthi_lo_keep got %h exp 2aaaaaaa", LO); end
    drive_cmd(3'd6, 32'h22, 32'd0);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got %b exp 0", Busy); end
    checks++; if (LO !== 32'h22) begin errors++; $display("FAIL mtlo_lo got %h exp 00000022", LO); end
    checks++; if (HI !== 32'h11) begin errors++; $display("FAIL mtlo_hi_keep got %h exp 00000011", HI); end
    // MDOp 0 and 7 with Start=1 do nothing.
    drive_cmd(3'd7, 32'hABCD, 32'd1);
    drive_cmd(3'd0, 32'hABCD, 32'd1);
    checks++; if (Busy !== 1'b0 || HI !== 32'h11 || LO !== 32'h22) begin
      errors++; $display("FAIL nop_ops got busy=%b hi=%h lo=%h exp 0/00000011/00000022", Busy, HI, LO);
    end
    // Divide by zero: full latency, HI/LO unchanged.
    drive_cmd(3'd3, 32'd5, 32'd0);
    wait_busy(cyc);
    checks++; if (cyc != DIV_N) begin errors++; $display("FAIL div0_busy_cycles got %0d exp %0d", cyc, DIV_N); end
    checks++; if (HI !== 32'h11) begin errors++; $display("FAIL div0_hi got %h exp 00000011", HI); end
    checks++; if (LO !== 32'h22) begin errors++; $display("FAIL div0_lo got %h exp 00000022", LO); end
    drive_cmd(3'd4, 32'd9, 32'd0);
    wait_busy(cyc);
    checks++; if (cyc != DIV_N) begin errors++; $display("FAIL divu0_busy_cycles got %0d exp %0d", cyc, DIV_N); end
    checks++; if (HI !== 32'h11 || LO !== 32'h22) begin
      errors++; $display("FAIL divu0_hilo got %h/%h exp 00000011/00000022", HI, LO);
    end
  endtask

  task automatic test_start_during_run;
    int cyc;
    // mult 6*7 = 42. HI/LO start at 0x11/0x22.
    drive_cmd(3'd1, 32'd6, 32'd7);
    cyc = 0;
    while (Busy === 1'b1 && cyc < BUSY_LIMIT) begin
      checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL run_stall cyc=%0d got %b exp 1", cyc, Stall); end
      checks++; if (HI !== 32'h11) begin errors++; $display("FAIL run_hi_hold cyc=%0d got %h exp 00000011", cyc, HI); end
      // Issue mthi for three cycles in the middle of the run.
      if (cyc >= 1 && cyc <= 3) begin
        Start = 1'b1; MDOp = 3'd5; A = 32'hDEAD;
      end else begin
        Start = 1'b0; MDOp = 3'd0; A = 32'd0;
      end
      cyc++;
      @(negedge clk);
    end
    Start = 1'b0; MDOp = 3'd0; A = 32'd0;
    checks++; if (cyc != MULT_N) begin errors++; $display("FAIL run_busy_cycles got %0d exp %0d", cyc, MULT_N); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL run_hi got %h exp 00000000", HI); end
    checks++; if (LO !== 32'd42) begin errors++; $display("FAIL run_lo got %h exp 0000002a", LO); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL run_stall_after got %b exp 0", Stall); end
    @(negedge clk);
    checks++; if (HI !== 32'd0 || dbg_state !== 1'b0) begin
      errors++; $display("FAIL run_no_leak got hi=%h state=%b exp 00000000/0", HI, dbg_state);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    // Stall rises combinationally in the same cycle as the Start.
    Start = 1'b1; MDOp = 3'd1; A = 32'd3; B = 32'd4;
    #1;
    checks++; if (Stall !== 1'b1 || Busy !== 1'b0) begin
      errors++; $display("FAIL b2b_stall_comb got stall=%b busy=%b exp 1/0", Stall, Busy);
    end
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0;
    wait_busy(cyc);
    checks++; if (cyc != MULT_N) begin errors++; $display("FAIL b2b_mult_cycles got %0d exp %0d", cyc, MULT_N); end
    checks++; if (LO !== 32'd12 || HI !== 32'd0) begin
      errors++; $display("FAIL b2b_mult_hilo got %h/%h exp 00000000/0000000c", HI, LO);
    end
    // divu starts on the first cycle Busy is low: 100 / 7 = 14 rem 2.
    drive_cmd(3'd4, 32'd100, 32'd7);
    wait_busy(cyc);
    checks++; if (cyc != DIV_N) begin errors++; $display("FAIL b2b_divu_cycles got %0d exp %0d", cyc, DIV_N); end
    checks++; if (LO !== 32'd14) begin errors++; $display("FAIL b2b_divu_lo got %h exp 0000000e", LO); end
    checks++; if (HI !== 32'd2) begin errors++; $display("FAIL b2b_divu_hi got %h exp 00000002", HI); end
  endtask

  task automatic test_reset_mid_div;
    // div 100 / 3 would give 33 rem 1. Reset lands in cycle 3 of the run.
    drive_cmd(3'd3, 32'd100, 32'd3);
    repeat (2) @(negedge clk);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_pre got %b exp 1", Busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", Busy); end
    checks++; if (HI !== 32'd0 || LO !== 32'd0) begin
      errors++; $display("FAIL rst_mid_hilo got %h/%h exp 00000000/00000000", HI, LO);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (Busy !== 1'b0 || dbg_state !== 1'b0) begin
      errors++; $display("FAIL rst_mid_idle got busy=%b state=%b exp 0/0", Busy, dbg_state);
    end
    checks++; if (HI !== 32'd0 || LO !== 32'd0) begin
      errors++; $display("FAIL rst_mid_no_update got %h/%h exp 00000000/00000000", HI, LO);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_mult;
    test_div;
    test_mthi_mtlo_div0;
    test_start_during_run;
    test_back_to_back;
    test_reset_mid_div;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
Multi-cycle multiply/divide sequencer for the EX stage of the pipelined MIPS core. It accepts mult/multu/div/divu/mthi/mtlo commands, owns the HI/LO registers, and runs a busy counter that models fixed operation latency. The hazard unit uses its Busy/Stall outputs to hold any MD instruction in ID while an operation is in flight.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high for mult/multu (must be >= 1)
DIV_CYCLES, 10, cycles Busy stays high for div/divu (must be >= 1)

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high reset
Start  input  1  command valid this cycle (EX-stage instruction is an MD op)
MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
A  input  32  operand rs (dividend / multiplicand / mthi-mtlo source)
B  input  32  operand rt (divisor / multiplier)
Busy  output  1  operation in flight
Stall  output  1  combinational Busy | (Start & MDOp in 1..4); to hazard unit
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset (async, any time incl. mid-operation): Busy=0, counter=0, HI=0, LO=0, pending result discarded; state IDLE.
- States: IDLE, RUN. Counter width sized for max(MULT_CYCLES, DIV_CYCLES).
- IDLE, Start=1, MDOp in 1..4 at edge k: compute result from A,B at edge k into pending HI/LO regs; load counter with N (MULT_CYCLES or DIV_CYCLES); Busy=1 after edge k; go RUN.
- RUN: counter decrements each edge; at edge k+N counter reaches 0, HI/LO <= pending, Busy=0, go IDLE. HI/LO keep old values during RUN.
- Start during RUN (any MDOp): ignored entirely; the hazard unit guarantees it does not occur; bench checks no state change.
- mthi (5)/mtlo (6) in IDLE: HI (resp. LO) <= A at that edge; other register unchanged; Busy stays 0; no RUN.
- MDOp 0 or 7 with Start=1: no effect.
- Start=0: MDOp/A/B ignored.
- Arithmetic: mult {HI,LO} = signed A*B 64-bit; multu unsigned 64-bit.
- div: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; divu unsigned quotient/remainder.
- Divide by zero (B=0, div/divu): full Busy timing still runs (DIV_CYCLES); at completion HI/LO left unchanged.
- Signed corner 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Back-to-back: new op may start at the same edge Busy falls only if Start arrives when Busy=0 (i.e., edge k+N+1 earliest); HI/LO readable combinationally from edge k+N.
- Stall is purely combinational; Busy, HI, LO are registered.

Test Plan:
- Reset then idle -> Busy=0, HI=0, LO=0, Stall=0; assert reset mid-div at cycle 3 -> Busy=0, HI/LO=0 immediately, no later update.
- mult A=0xFFFFFFFE(-2) B=3 -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9(-7) B=2 -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7 B=2 -> LO=3, HI=1.
- HI=0x11,LO=0x22 preloaded via mthi/mtlo (1 cycle each, Busy never set); div by B=0 -> Busy 10 cycles, HI=0x11, LO=0x22 after.
- During mult RUN issue Start with mthi A=0xDEAD -> ignored; final HI/LO equal mult result; Stall=1 throughout RUN, 0 after.
- Start mult with Busy=0 -> Stall=1 same cycle combinationally; back-to-back mult then divu -> second result lands exactly DIV_CYCLES after its Start.
